// File: rtl/apb_pkg.sv
// Shared APB types used by the team's APB agent and by the apb_completer_mem target.
package apb_pkg;

  // Bit 1 of pprot flags a non-secure access.
  localparam int APB_PPROT_NONSECURE_BIT = 1;

  typedef logic [2:0] apb_pprot_t;

  typedef enum logic {
    APB_READ  = 1'b0,
    APB_WRITE = 1'b1
  } apb_write_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_completer_state_e;

endpackage

// File: rtl/apb_completer_ram.sv
// DEPTH x DATA_WIDTH storage for apb_completer_mem: synchronous clear,
// byte-enabled write port and asynchronous read port.
module apb_completer_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: clearing every word on reset forces flops instead of a RAM macro;
  // acceptable at this size and required so reads after reset return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer over a byte-enabled word array with programmable wait states.
// Define APB_COMPLETER_PROT_CHECK_EN to reject non-secure accesses to the upper half.
module apb_completer_mem
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 16,
  parameter int unsigned BASE_ADDR   = 'h100,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  apb_pprot_t              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  apb_write_t              pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);
`ifdef APB_COMPLETER_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  apb_completer_state_e state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  apb_write_t            write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;
  apb_pprot_t            prot_q;
  logic                  capture, commit;

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      index;
  logic                  prot_err, err;
  logic [DATA_WIDTH-1:0] rdata;

  // Decode works only on the captured request, so outputs never see live inputs.
  assign offset   = addr_q - BASE;
  assign index    = offset[ALIGN +: IDX_W];
  assign prot_err = PROT_EN && prot_q[APB_PPROT_NONSECURE_BIT] && index[IDX_W-1];
  assign err      = (addr_q < BASE) || (offset >= SPAN) ||
                    ((offset & ALIGN_MASK) != '0) || prot_err;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          capture = 1'b1;
          cnt_d   = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (!penable) begin
          // Setup seen mid-access: restart with the new request.
          capture = 1'b1;
          cnt_d   = WAIT_LOAD;
        end else if (cnt_q == '0) begin
          commit  = (write_q == APB_WRITE) && !err;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= APB_READ;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        prot_q  <= pprot;
      end
    end
  end

  apb_completer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (pclk),
    .rst   (preset),
    .we    (commit),
    .idx   (index),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (rdata)
  );

  assign pready  = (state_q == ACCESS) && (cnt_q == '0);
  assign pslverr = pready && err;
  assign prdata  = (pready && !err && write_q == APB_READ) ? rdata : '0;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem: a zero-wait and a two-wait instance
// share one bus; each is selected by its own psel.
module tb_apb_completer_mem;
  import apb_pkg::*;

`ifdef APB_COMPLETER_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic [15:0] paddr;
  apb_pprot_t  pprot;
  logic        psel0, psel2, penable;
  apb_write_t  pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready0, pslverr0, pready2, pslverr2;
  logic [31:0] prdata0, prdata2;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_completer_mem #(.WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .psel(psel0),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

  apb_completer_mem #(.WAIT_CYCLES(2)) u_dut2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .psel(psel2),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready2), .prdata(prdata2), .pslverr(pslverr2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transfer on the selected instance; stimulus driven and outputs sampled at negedge.
  task automatic xfer(input int sel, input apb_write_t wr, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input apb_pprot_t prot,
                      output logic [31:0] rdata, output logic err, output int waits);
    logic rdy;
    @(negedge pclk);
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
    psel0 = (sel == 0); psel2 = (sel == 2); penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    // Scramble inputs: the captured request must be used.
    paddr = 16'h0000; pwdata = 32'h0; pstrb = 4'h0;
    waits = 0;
    rdy = (sel == 0) ? pready0 : pready2;
    while (!rdy && waits < 20) begin
      @(negedge pclk);
      waits++;
      rdy = (sel == 0) ? pready0 : pready2;
    end
    if (!rdy) check("pready_timeout", 32'(rdy), 32'd1);
    rdata = (sel == 0) ? prdata0 : prdata2;
    err   = (sel == 0) ? pslverr0 : pslverr2;
    @(negedge pclk);
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    preset = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = APB_READ; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (2) @(negedge pclk);
    check("rst_pready", 32'(pready0), 32'd0);
    check("rst_prdata", prdata0, 32'd0);
    check("rst_pslverr", 32'(pslverr0), 32'd0);
    preset = 1'b0;

    // Zero-wait write then read.
    xfer(0, APB_WRITE, 16'h104, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w);
    check("w0_waits", w, 0);
    check("w0_err", 32'(er), 32'd0);
    xfer(0, APB_READ, 16'h104, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("r0_waits", w, 0);
    check("r0_data", rd, 32'hDEADBEEF);
    check("r0_err", 32'(er), 32'd0);
    check("idle_prdata", prdata0, 32'd0);

    // Two-wait read after reset.
    xfer(2, APB_READ, 16'h100, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("r2_waits", w, 2);
    check("r2_data", rd, 32'h0);

    // Partial strobes.
    xfer(0, APB_WRITE, 16'h108, 32'hAABBCCDD, 4'hF, 3'b000, rd, er, w);
    xfer(0, APB_WRITE, 16'h108, 32'h11223344, 4'h5, 3'b000, rd, er, w);
    xfer(0, APB_READ, 16'h108, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("strb_data", rd, 32'hAA22CC44);
    xfer(0, APB_WRITE, 16'h108, 32'h55555555, 4'h0, 3'b000, rd, er, w);
    check("strb0_err", 32'(er), 32'd0);
    xfer(0, APB_READ, 16'h108, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("strb0_data", rd, 32'hAA22CC44);

    // Error responses: below base, past end, misaligned.
    xfer(0, APB_WRITE, 16'h0FC, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, w);
    check("err_low", 32'(er), 32'd1);
    xfer(0, APB_READ, 16'h140, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("err_high", 32'(er), 32'd1);
    check("err_high_rdata", rd, 32'd0);
    xfer(0, APB_WRITE, 16'h102, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, w);
    check("err_misalign", 32'(er), 32'd1);
    xfer(0, APB_READ, 16'h100, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("err_nowrite", rd, 32'd0);
    check("err_nowrite_ok", 32'(er), 32'd0);
    xfer(0, APB_READ, 16'h13C, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("last_word_ok", 32'(er), 32'd0);

    // Abort: drop psel during the wait on the two-wait instance.
    @(negedge pclk);
    paddr = 16'h108; pwrite = APB_WRITE; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    psel2 = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel2 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort_pready", 32'(pready2), 32'd0);
    xfer(2, APB_READ, 16'h108, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("abort_data", rd, 32'd0);
    check("abort_waits", w, 2);

    // Protection: index 8 is in the secure half.
    xfer(0, APB_WRITE, 16'h120, 32'h12345678, 4'hF, 3'b010, rd, er, w);
    check("prot_ns_err", 32'(er), 32'(PROT_EN));
    xfer(0, APB_READ, 16'h120, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("prot_ns_data", rd, PROT_EN ? 32'h0 : 32'h12345678);
    xfer(0, APB_WRITE, 16'h120, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, w);
    check("prot_s_err", 32'(er), 32'd0);
    xfer(0, APB_READ, 16'h120, 32'h0, 4'h0, 3'b010, rd, er, w);
    check("prot_ns_rd_err", 32'(er), 32'(PROT_EN));
    xfer(0, APB_READ, 16'h11C, 32'h0, 4'h0, 3'b010, rd, er, w);
    check("prot_ns_low_ok", 32'(er), 32'd0);

    // Reset during an access on the two-wait instance.
    @(negedge pclk);
    paddr = 16'h104; pwrite = APB_READ; psel2 = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    preset = 1'b1;
    @(negedge pclk);
    check("rst_mid_pready", 32'(pready2), 32'd0);
    check("rst_mid_pslverr", 32'(pslverr2), 32'd0);
    check("rst_mid_prdata", prdata2, 32'd0);
    preset = 1'b0; psel2 = 1'b0; penable = 1'b0;
    xfer(0, APB_READ, 16'h104, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("rst_cleared", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
